// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared types and constants for the iterative CORDIC engine.
//   cordic_mode_e   : per-transaction operating mode (rotate / vector)
//   cordic_state_e  : engine sequencing states
//   CORDIC_GAIN_Q15 : CORDIC gain K (~1.6468) in Q15, for downstream compensation
//   quarter_turn()  : pi/2 in the angle encoding where 2^(bw-1) = pi
// -----------------------------------------------------------------------------
package cordic_pkg;

  typedef enum logic {
    CORDIC_ROTATE = 1'b0,
    CORDIC_VECTOR = 1'b1
  } cordic_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } cordic_state_e;

  localparam int CORDIC_GAIN_Q15 = 53963;

  function automatic int quarter_turn(input int bw);
    return 1 << (bw - 2);
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// -----------------------------------------------------------------------------
// cordic_atan_rom
// Combinational arctangent table: atan_o = round(atan(2^-idx) * 2^(BW-1) / pi).
// Entries are computed at elaboration; indices at or beyond BIT_WIDTH return 0.
//   idx_i  : micro-rotation index
//   atan_o : arctangent in the engine's angle encoding (always non-negative)
// -----------------------------------------------------------------------------
module cordic_atan_rom #(
  parameter int BIT_WIDTH   = 16,
  parameter int INDEX_WIDTH = 4
) (
  input  logic [INDEX_WIDTH-1:0] idx_i,
  output logic [BIT_WIDTH-1:0]   atan_o
);

  localparam real PI = 3.14159265358979323846;

  logic [BIT_WIDTH-1:0] table_w [BIT_WIDTH];

  for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_entry
    localparam real ANG = $atan(1.0 / (2.0 ** i)) * (2.0 ** (BIT_WIDTH - 1)) / PI;
    localparam int  VAL = $rtoi(ANG + 0.5);
    assign table_w[i] = BIT_WIDTH'(VAL);
  end

  // Compare at 32 bits so a wide index never aliases onto a valid entry.
  always_comb begin
    atan_o = '0;
    for (int k = 0; k < BIT_WIDTH; k++) begin
      if (32'(idx_i) == k) atan_o = table_w[k];
    end
  end

endmodule

// File: rtl/cordic_iter_engine.sv
// -----------------------------------------------------------------------------
// cordic_iter_engine
// Iterative CORDIC, one micro-rotation per clock. Rotation mode drives z to 0
// (sin/cos, vector rotate); vectoring mode drives y to 0 (magnitude/atan2).
// Results carry the uncompensated gain K.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake; in_mode, in_x, in_y, in_z operands
//   out_valid/out_ready  : output handshake; out_x, out_y (BW+2), out_z (BW)
//
// state | meaning
// IDLE  | ready for a new operand set
// PRE   | quadrant pre-rotation by +/- pi/2 into the convergence range
// ITER  | micro-rotation i = cnt_q, ITERATIONS cycles
// DONE  | result valid, held until out_ready
// -----------------------------------------------------------------------------
module cordic_iter_engine
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int ITERATIONS = 14
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_mode,
  input  logic signed [BIT_WIDTH-1:0] in_x,
  input  logic signed [BIT_WIDTH-1:0] in_y,
  input  logic signed [BIT_WIDTH-1:0] in_z,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [BIT_WIDTH+1:0] out_x,
  output logic signed [BIT_WIDTH+1:0] out_y,
  output logic signed [BIT_WIDTH-1:0] out_z
);

  localparam int INDEX_WIDTH = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam int XW          = BIT_WIDTH + 2;
  localparam logic signed [BIT_WIDTH-1:0]   QUARTER   = BIT_WIDTH'(quarter_turn(BIT_WIDTH));
  localparam logic        [INDEX_WIDTH-1:0] LAST_ITER = INDEX_WIDTH'(ITERATIONS - 1);

  cordic_state_e                state_q;
  cordic_mode_e                 mode_q;
  logic        [INDEX_WIDTH-1:0] cnt_q;
  logic signed [XW-1:0]          x_q, y_q;
  logic signed [BIT_WIDTH-1:0]   z_q;

  logic signed [XW-1:0]        pre_x_d, pre_y_d, it_x_d, it_y_d, x_sh, y_sh;
  logic signed [BIT_WIDTH-1:0] pre_z_d, it_z_d;
  logic        [BIT_WIDTH-1:0] atan_val;
  logic                        dir_pos;

  cordic_atan_rom #(
    .BIT_WIDTH  (BIT_WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_atan_rom (
    .idx_i (cnt_q),
    .atan_o(atan_val)
  );

  // Quadrant pre-rotation; guard bits make the negations overflow-free.
  always_comb begin
    pre_x_d = x_q;
    pre_y_d = y_q;
    pre_z_d = z_q;
    if (mode_q == CORDIC_ROTATE) begin
      if (z_q >= QUARTER) begin
        pre_x_d = -y_q;
        pre_y_d = x_q;
        pre_z_d = z_q - QUARTER;
      end else if (z_q < -QUARTER) begin
        pre_x_d = y_q;
        pre_y_d = -x_q;
        pre_z_d = z_q + QUARTER;
      end
    end else if (x_q[XW-1]) begin
      if (!y_q[XW-1]) begin
        pre_x_d = y_q;
        pre_y_d = -x_q;
        pre_z_d = z_q + QUARTER;
      end else begin
        pre_x_d = -y_q;
        pre_y_d = x_q;
        pre_z_d = z_q - QUARTER;
      end
    end
  end

  always_comb begin
    x_sh    = x_q >>> cnt_q;
    y_sh    = y_q >>> cnt_q;
    dir_pos = (mode_q == CORDIC_ROTATE) ? ~z_q[BIT_WIDTH-1] : y_q[XW-1];
    if (dir_pos) begin
      it_x_d = x_q - y_sh;
      it_y_d = y_q + x_sh;
      it_z_d = z_q - $signed(atan_val);
    end else begin
      it_x_d = x_q + y_sh;
      it_y_d = y_q - x_sh;
      it_z_d = z_q + $signed(atan_val);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= CORDIC_ROTATE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mode_q  <= cordic_mode_e'(in_mode);
            x_q     <= {{2{in_x[BIT_WIDTH-1]}}, in_x};
            y_q     <= {{2{in_y[BIT_WIDTH-1]}}, in_y};
            z_q     <= in_z;
            state_q <= PRE;
          end
        end
        PRE: begin
          x_q     <= pre_x_d;
          y_q     <= pre_y_d;
          z_q     <= pre_z_d;
          cnt_q   <= '0;
          state_q <= ITER;
        end
        ITER: begin
          x_q <= it_x_d;
          y_q <= it_y_d;
          z_q <= it_z_d;
          if (cnt_q == LAST_ITER) state_q <= DONE;
          else                    cnt_q   <= cnt_q + 1'b1;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_z     = z_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
module tb_cordic_iter_engine;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               in_mode = 1'b0;
  logic signed [15:0] in_x = '0, in_y = '0, in_z = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [17:0] out_x, out_y;
  logic signed [15:0] out_z;

  int checks = 0;
  int errors = 0;

  cordic_iter_engine #(.BIT_WIDTH(16), .ITERATIONS(14)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_x     (in_x),
    .in_y     (in_y),
    .in_z     (in_z),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_x    (out_x),
    .out_y    (out_y),
    .out_z    (out_z)
  );

  always #5 clk = ~clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Drives one transaction from IDLE and returns the accept-to-valid latency
  // (cycles) and the result; out_ready is pulsed for one cycle afterwards.
  task automatic run_txn(input logic m, input int x, input int y, input int z,
                         output int lat, output logic signed [17:0] rx,
                         output logic signed [17:0] ry, output logic signed [15:0] rz);
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = m;
    in_x     = 16'(x);
    in_y     = 16'(y);
    in_z     = 16'(z);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    rx = out_x;
    ry = out_y;
    rz = out_z;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    checks++;
    if (out_x !== 18'sd0 || out_y !== 18'sd0 || out_z !== 16'sd0) begin
      errors++;
      $display("FAIL reset_out got %0d %0d %0d want 0 0 0", out_x, out_y, out_z);
    end
  endtask

  task automatic test_rotation();
    int lat;
    logic signed [17:0] rx, ry;
    logic signed [15:0] rz;
    // 45 degrees
    run_txn(1'b0, 10000, 0, 8192, lat, rx, ry, rz);
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL rot45_latency got %0d want 16", lat); end
    checks++;
    if (iabs(int'(rx) - 11645) > 4) begin errors++; $display("FAIL rot45_x got %0d want 11645+-4", rx); end
    checks++;
    if (iabs(int'(ry) - 11645) > 4) begin errors++; $display("FAIL rot45_y got %0d want 11645+-4", ry); end
    checks++;
    if (iabs(int'(rz)) > 2) begin errors++; $display("FAIL rot45_z got %0d want 0+-2", rz); end
    // exactly pi/2: pre-rotation path
    run_txn(1'b0, 10000, 0, 16384, lat, rx, ry, rz);
    checks++;
    if (iabs(int'(rx)) > 4) begin errors++; $display("FAIL rot90_x got %0d want 0+-4", rx); end
    checks++;
    if (iabs(int'(ry) - 16468) > 4) begin errors++; $display("FAIL rot90_y got %0d want 16468+-4", ry); end
    // exactly -pi/2: no pre-rotation, iterations alone reach it
    run_txn(1'b0, 10000, 0, -16384, lat, rx, ry, rz);
    checks++;
    if (iabs(int'(rx)) > 6) begin errors++; $display("FAIL rotm90_x got %0d want 0+-6", rx); end
    checks++;
    if (iabs(int'(ry) + 16468) > 6) begin errors++; $display("FAIL rotm90_y got %0d want -16468+-6", ry); end
    // -135 degrees: below -pi/2
    run_txn(1'b0, 10000, 0, -24576, lat, rx, ry, rz);
    checks++;
    if (iabs(int'(rx) + 11645) > 6) begin errors++; $display("FAIL rotm135_x got %0d want -11645+-6", rx); end
    checks++;
    if (iabs(int'(ry) + 11645) > 6) begin errors++; $display("FAIL rotm135_y got %0d want -11645+-6", ry); end
  endtask

  task automatic test_vectoring();
    int lat;
    logic signed [17:0] rx, ry;
    logic signed [15:0] rz, dz;
    run_txn(1'b1, 10000, 10000, 0, lat, rx, ry, rz);
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL vec_latency got %0d want 16", lat); end
    checks++;
    if (iabs(int'(rx) - 23290) > 6) begin errors++; $display("FAIL vec45_x got %0d want 23290+-6", rx); end
    checks++;
    if (iabs(int'(ry)) > 4) begin errors++; $display("FAIL vec45_y got %0d want 0+-4", ry); end
    checks++;
    if (iabs(int'(rz) - 8192) > 2) begin errors++; $display("FAIL vec45_z got %0d want 8192+-2", rz); end
    // negative x axis: angle pi wraps to -32768
    run_txn(1'b1, -10000, 0, 0, lat, rx, ry, rz);
    dz = rz - 16'sh8000;
    checks++;
    if (iabs(int'(rx) - 16468) > 4) begin errors++; $display("FAIL vec180_x got %0d want 16468+-4", rx); end
    checks++;
    if (iabs(int'(ry)) > 4) begin errors++; $display("FAIL vec180_y got %0d want 0+-4", ry); end
    checks++;
    if (iabs(int'(dz)) > 2) begin errors++; $display("FAIL vec180_z got %0d want -32768+-2 mod 2^16", rz); end
    // third quadrant: x<0, y<0 -> -135 degrees
    run_txn(1'b1, -10000, -10000, 0, lat, rx, ry, rz);
    checks++;
    if (iabs(int'(rx) - 23290) > 6) begin errors++; $display("FAIL vecm135_x got %0d want 23290+-6", rx); end
    checks++;
    if (iabs(int'(rz) + 24576) > 2) begin errors++; $display("FAIL vecm135_z got %0d want -24576+-2", rz); end
  endtask

  task automatic test_backpressure();
    int lat;
    logic signed [17:0] hx, hy;
    logic signed [15:0] hz;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 1'b1;
    in_x = 16'sd10000; in_y = 16'sd10000; in_z = 16'sd0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL bp_latency got %0d want 16", lat); end
    hx = out_x; hy = out_y; hz = out_z;
    checks++;
    if (iabs(int'(hx) - 23290) > 6) begin errors++; $display("FAIL bp_first_x got %0d want 23290+-6", hx); end
    // competing input while the result is stalled
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_x = 16'sd10000; in_y = 16'sd0; in_z = 16'sd8192;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_hs cyc %0d got out_valid=%b in_ready=%b want 1/0", c, out_valid, in_ready);
      end
      checks++;
      if (out_x !== hx || out_y !== hy || out_z !== hz) begin
        errors++;
        $display("FAIL bp_hold_data cyc %0d got %0d %0d %0d want %0d %0d %0d",
                 c, out_x, out_y, out_z, hx, hy, hz);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_after_hs got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL bp_second_latency got %0d want 16", lat); end
    checks++;
    if (iabs(int'(out_x) - 11645) > 4 || iabs(int'(out_y) - 11645) > 4) begin
      errors++;
      $display("FAIL bp_second_xy got %0d %0d want 11645 11645 +-4", out_x, out_y);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int seen;
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_x = 16'sd10000; in_y = 16'sd0; in_z = 16'sd8192;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_hs got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    checks++;
    if (out_x !== 18'sd0 || out_y !== 18'sd0 || out_z !== 16'sd0) begin
      errors++;
      $display("FAIL rstmid_out got %0d %0d %0d want 0 0 0", out_x, out_y, out_z);
    end
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rstmid_no_output got %0d valid cycles want 0", seen); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_vectoring();
    test_backpressure();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
